// File: rtl/stream_pkg.sv
// Shared FSM encoding and width helper for the stream arbiter slice.
package stream_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_arb_rr.sv
// Rotating-priority picker: returns the first set req bit after index last,
// wrapping modulo N.
module stream_arb_rr
    import stream_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W:0] pos;

    // Scan from the farthest candidate down so the nearest one after last wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = N; k >= 1; k--) begin
            pos = {1'b0, last} + (W+1)'(k);
            if (pos >= (W+1)'(N)) pos = pos - (W+1)'(N);
            if (req[pos[W-1:0]]) begin
                idx = pos[W-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// Round-robin arbiter sharing one stream sink among N sources, up to BL beats per
// grant, through a one-deep output register. STREAM_ARB_SEL_EN adds out_sel.
//
//   state   | meaning
//   ST_IDLE | no grant held; picks the next requester after last
//   ST_BUSY | grant held; forwards beats until BL beats or source goes idle
module stream_arbiter
    import stream_pkg::*;
#(
    parameter int DW = 8,
    parameter int N  = 4,
    parameter int BL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        in_vld,
    input  logic [N*DW-1:0]     in_dat,
    output logic [N-1:0]        in_rdy,
    output logic                out_vld,
    output logic [DW-1:0]       out_dat,
`ifdef STREAM_ARB_SEL_EN
    output logic [clog2(N)-1:0] out_sel,
`endif
    input  logic                out_rdy
);

    localparam int GW = clog2(N);
    localparam int BW = clog2(BL) + 1;

    arb_state_t    state;
    logic [GW-1:0] grant;
    logic [GW-1:0] last;
    logic [GW-1:0] pick_idx;
    logic          pick_any;
    logic [BW-1:0] beat;
    logic          ld;
    logic          in_beat;
    logic [DW-1:0] dat_arr [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign dat_arr[g] = in_dat[g*DW +: DW];
    end

    stream_arb_rr #(
        .N (N),
        .W (GW)
    ) u_rr (
        .req  (in_vld),
        .last (last),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign ld      = ~out_vld | out_rdy;
    assign in_beat = (state == ST_BUSY) & in_vld[grant] & ld;

    always_comb begin
        in_rdy = '0;
        if (state == ST_BUSY && ld) in_rdy[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            grant   <= '0;
            last    <= GW'(N-1);
            beat    <= '0;
            out_vld <= 1'b0;
            out_dat <= '0;
`ifdef STREAM_ARB_SEL_EN
            out_sel <= '0;
`endif
        end else begin
            if (ld) begin
                out_vld <= in_beat;
                if (in_beat) begin
                    out_dat <= dat_arr[grant];
`ifdef STREAM_ARB_SEL_EN
                    out_sel <= grant;
`endif
                end
            end
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant <= pick_idx;
                        beat  <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_beat) begin
                        if (beat == BW'(BL-1)) begin
                            last  <= grant;
                            state <= ST_IDLE;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end else if (!in_vld[grant]) begin
                        // Source went quiet: release without losing anything.
                        last  <= grant;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed and randomized checks of stream_arbiter (BL=4 instance plus a BL=1 instance).
module tb_stream_arbiter;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int BL = 4;
    localparam int NV = 39;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    in_vld, in_rdy, vld1, rdy1;
    logic [N*DW-1:0] in_dat, dat1;
    logic            out_vld, out_rdy, ovld1, ordy1;
    logic [DW-1:0]   out_dat, odat1;
`ifdef STREAM_ARB_SEL_EN
    logic [1:0]      out_sel, osel1;
`endif

    logic [7:0] cnt  [N];
    logic [7:0] cnt1 [N];

    for (genvar g = 0; g < N; g++) begin : g_dat
        assign in_dat[g*DW +: DW] = cnt[g];
        assign dat1[g*DW +: DW]   = cnt1[g];
    end

    stream_arbiter #(.DW(DW), .N(N), .BL(BL)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_dat  (in_dat),
        .in_rdy  (in_rdy),
        .out_vld (out_vld),
        .out_dat (out_dat),
`ifdef STREAM_ARB_SEL_EN
        .out_sel (out_sel),
`endif
        .out_rdy (out_rdy)
    );

    stream_arbiter #(.DW(DW), .N(N), .BL(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (vld1),
        .in_dat  (dat1),
        .in_rdy  (rdy1),
        .out_vld (ovld1),
        .out_dat (odat1),
`ifdef STREAM_ARB_SEL_EN
        .out_sel (osel1),
`endif
        .out_rdy (ordy1)
    );

    typedef struct {
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] e_rdy;
        logic       e_ovld;
        logic [7:0] e_dat;
    } vec_t;

    vec_t tv [NV];

    int n_cmp = 0;
    int n_bad = 0;
    logic [N-1:0] hs, hs1;
    bit   rnd_on;
    int   total_in, total_out, max_wait;
    int   wait_cnt [N];
    logic [5:0] exp_seq [N];
    logic [7:0] q1 [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic half();
        logic [1:0] src;
        @(negedge clk);
        hs  = in_vld & in_rdy;
        hs1 = vld1 & rdy1;
        if (ovld1 && ordy1) q1.push_back(odat1);
        if (rnd_on) begin
            for (int i = 0; i < N; i++) begin
                if (hs[i]) total_in++;
                if (hs[i] || !in_vld[i]) wait_cnt[i] = 0;
                else if (out_rdy) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end
            end
            if (out_vld && out_rdy) begin
                src = out_dat[7:6];
                chk($sformatf("t6_order_src%0d", src), 32'(out_dat[5:0]), 32'(exp_seq[src]));
`ifdef STREAM_ARB_SEL_EN
                chk("t6_out_sel", 32'(out_sel), 32'(src));
`endif
                exp_seq[src] = exp_seq[src] + 6'd1;
                total_out++;
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i])  cnt[i]  = {cnt[i][7:6],  cnt[i][5:0]  + 6'd1};
            if (hs1[i]) cnt1[i] = {cnt1[i][7:6], cnt1[i][5:0] + 6'd1};
        end
        hs  = '0;
        hs1 = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] nxt_vld;
        logic         nxt_rdy;

        rst = 1'b0; in_vld = '0; out_rdy = 1'b1; vld1 = '0; ordy1 = 1'b1;
        rnd_on = 1'b0; hs = '0; hs1 = '0;
        total_in = 0; total_out = 0; max_wait = 0;
        for (int i = 0; i < N; i++) begin
            cnt[i]  = {2'(i), 6'd0};
            cnt1[i] = {2'(i), 6'd0};
            wait_cnt[i] = 0;
            exp_seq[i]  = '0;
        end
        cnt[2] = 8'h10;

        // vld, out_rdy, expected in_rdy, expected out_vld, expected out_dat
        tv[0]  = '{4'b0100, 1'b1, 4'b0000, 1'b0, 8'h00};
        tv[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 8'h00};
        tv[2]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'h10};
        tv[3]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'h11};
        tv[4]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'h12};
        tv[5]  = '{4'b0100, 1'b1, 4'b0000, 1'b1, 8'h13};
        tv[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 8'h13};
        tv[7]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'h14};
        tv[8]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'h15};
        tv[9]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'h16};
        tv[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'h17};
        tv[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h17};
        tv[12] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 8'h17};
        tv[13] = '{4'b1010, 1'b1, 4'b0010, 1'b0, 8'h17};
        tv[14] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 8'h40};
        tv[15] = '{4'b1000, 1'b1, 4'b0010, 1'b1, 8'h41};
        tv[16] = '{4'b1010, 1'b1, 4'b0000, 1'b0, 8'h41};
        tv[17] = '{4'b1010, 1'b1, 4'b1000, 1'b0, 8'h41};
        tv[18] = '{4'b0010, 1'b1, 4'b1000, 1'b1, 8'hC0};
        tv[19] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 8'hC0};
        tv[20] = '{4'b0010, 1'b1, 4'b0010, 1'b0, 8'hC0};
        tv[21] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 8'h42};
        tv[22] = '{4'b0000, 1'b1, 4'b0010, 1'b1, 8'h43};
        tv[23] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h43};
        tv[24] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 8'h43};
        tv[25] = '{4'b1111, 1'b1, 4'b0100, 1'b0, 8'h43};
        for (int k = 26; k <= 30; k++) tv[k] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h18};
        tv[31] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'h18};
        tv[32] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'h19};
        tv[33] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'h1A};
        tv[34] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h1B};
        tv[35] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h1B};
        tv[36] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'h1B};
        tv[37] = '{4'b0000, 1'b1, 4'b1000, 1'b1, 8'hC1};
        tv[38] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'hC1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_in_rdy",  32'(in_rdy),  32'd0);
        chk("rst_out_dat", 32'(out_dat), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single source bursts, idle release with a waiting source, backpressure.
        for (int k = 0; k < NV; k++) begin
            in_vld  = tv[k].vld;
            out_rdy = tv[k].ordy;
            half();
            chk($sformatf("v%0d_in_rdy", k),  32'(in_rdy),  32'(tv[k].e_rdy));
            chk($sformatf("v%0d_out_vld", k), 32'(out_vld), 32'(tv[k].e_ovld));
            chk($sformatf("v%0d_out_dat", k), 32'(out_dat), 32'(tv[k].e_dat));
            adv();
        end

        // Reset in the middle of src1's grant, after src0 completed a full grant.
        in_vld = 4'b1111; out_rdy = 1'b1;
        repeat (7) begin half(); adv(); end
        half();
        chk("t5_pre_out_vld", 32'(out_vld), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_out_vld", 32'(out_vld), 32'd0);
        chk("t5_rst_in_rdy",  32'(in_rdy),  32'd0);
        hs = '0; hs1 = '0;
        @(posedge clk);
        #1;
        in_vld = 4'b1010;
        @(negedge clk);
        chk("t5_hold_out_vld", 32'(out_vld), 32'd0);
        chk("t5_hold_in_rdy",  32'(in_rdy),  32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        half();
        chk("t5_first_grant", 32'(in_rdy), 32'b0010);
        adv();

        // BL=1 instance: strict rotation 0,1,2,3,...
        in_vld = '0;
        for (int i = 0; i < N; i++) cnt1[i] = {2'(i), 6'd0};
        q1.delete();
        vld1 = 4'b1111;
        for (int c = 0; c < 200 && q1.size() < 12; c++) begin half(); adv(); end
        vld1 = '0;
        chk("t2_beat_count", 32'(q1.size()), 32'd12);
        for (int j = 0; j < 12 && j < q1.size(); j++)
            chk($sformatf("t2_beat%0d", j), 32'(q1[j]), 32'({2'(j % 4), 6'(j / 4)}));

        // Randomized traffic with a scoreboard per source.
        in_vld = '0; out_rdy = 1'b1;
        repeat (6) begin half(); adv(); end
        for (int i = 0; i < N; i++) begin
            cnt[i] = {2'(i), 6'd0};
            exp_seq[i] = '0;
            wait_cnt[i] = 0;
        end
        total_in = 0; total_out = 0; max_wait = 0;
        rnd_on = 1'b1;
        for (int c = 0; c < 20000 && total_out < 1000; c++) begin
            half();
            for (int i = 0; i < N; i++)
                nxt_vld[i] = (in_vld[i] && !hs[i]) ? 1'b1 : 1'($urandom_range(0, 1));
            nxt_rdy = 1'($urandom_range(0, 1));
            adv();
            in_vld  = nxt_vld;
            out_rdy = nxt_rdy;
        end
        in_vld = '0; out_rdy = 1'b1;
        repeat (10) begin half(); adv(); end
        rnd_on = 1'b0;
        chk("t6_reached_1000", 32'(total_out >= 1000), 32'd1);
        chk("t6_in_vs_out",    32'(total_out), 32'(total_in));
        chk("t6_starvation",   32'(max_wait <= N * (BL + 1)), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
